// File: rtl/uart_rx_stdin_pkg.sv
// Shared definitions for the stdin UART receiver: receiver state encoding and
// baud-rate divisors (system clocks per bit at a 50 MHz system clock).
package uart_rx_stdin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam int B115200 = 434;
  localparam int B57600  = 868;
  localparam int B38400  = 1302;
  localparam int B19200  = 2604;
  localparam int B9600   = 5208;

endpackage

// File: rtl/uart_rx_stdin_fifo.sv
// Show-ahead byte FIFO between the UART deframer and the core's stdin port.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module rx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_push,
  input  logic [7:0] i_wdata,
  input  logic       i_pop,
  output logic [7:0] o_rdata,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic        w_do_push;
  logic        w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A pop on the same edge frees the slot the push lands in, so full is no obstacle then.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr[AW-1:0]] <= i_wdata;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_do_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_stdin.sv
// 8N1 UART receiver feeding the processor's stdin stream through a small FIFO,
// with one-cycle pulses for framing errors and for bytes dropped on overrun.
module uart_rx_stdin
  import uart_rx_stdin_pkg::*;
#(
  parameter int BAUD       = B115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] stdin_data,
  output logic       stdin_valid,
  input  logic       stdin_ready,
  output logic       frame_err,
  output logic       overrun,
  output rx_state_e  o_dbg_state
);

  localparam int CW = $clog2(BAUD);

  logic [1:0]    r_sync;
  rx_state_e     r_state;
  rx_state_e     w_next;
  logic [CW-1:0] r_baud_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_frame_err;
  logic          r_overrun;

  logic w_rxs;
  logic w_tick;
  logic w_load_half;
  logic w_load_full;
  logic w_shift_en;
  logic w_clr_bits;
  logic w_stop_done;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], rx};
  end

  assign w_rxs  = r_sync[1];
  assign w_tick = (r_baud_cnt == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (!w_rxs) w_next = ST_START;
      ST_START: if (w_tick) w_next = w_rxs ? ST_IDLE : ST_DATA;
      ST_DATA:  if (w_tick && (r_bit_cnt == 3'd7)) w_next = ST_STOP;
      // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
      ST_STOP:  if (w_tick) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_load_half = 1'b0;
    w_load_full = 1'b0;
    w_shift_en  = 1'b0;
    w_clr_bits  = 1'b0;
    w_stop_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_clr_bits  = 1'b1;
        w_load_half = !w_rxs;
      end
      ST_START: w_load_full = w_tick && !w_rxs;
      ST_DATA: begin
        w_shift_en  = w_tick;
        w_load_full = w_tick;
      end
      ST_STOP:  w_stop_done = w_tick;
      default:  w_clr_bits  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
    end else begin
      if (w_load_half)        r_baud_cnt <= CW'(BAUD / 2 - 1);
      else if (w_load_full)   r_baud_cnt <= CW'(BAUD - 1);
      else if (!w_tick)       r_baud_cnt <= r_baud_cnt - CW'(1);
      if (w_clr_bits)         r_bit_cnt  <= '0;
      else if (w_shift_en)    r_bit_cnt  <= r_bit_cnt + 3'd1;
      if (w_shift_en)         r_shift    <= {w_rxs, r_shift[7:1]};
    end
  end

  assign w_push = w_stop_done && w_rxs;
  assign w_pop  = stdin_valid && stdin_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_stop_done && !w_rxs;
      r_overrun   <= w_push && w_full && !w_pop;
    end
  end

  rx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_wdata (r_shift),
    .i_pop   (w_pop),
    .o_rdata (stdin_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign stdin_valid = !w_empty;
  assign frame_err   = r_frame_err;
  assign overrun     = r_overrun;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx_stdin.sv
// Bench for uart_rx_stdin at 16 clocks/bit, FIFO depth 4: frame table, timed
// corner sequences, and a randomized stream checked against a byte-level model.
module tb_uart_rx_stdin;
  import uart_rx_stdin_pkg::*;

  localparam int BAUD = 16;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx = 1'b1;
  logic       stdin_ready = 1'b0;
  logic [7:0] stdin_data;
  logic       stdin_valid;
  logic       frame_err;
  logic       overrun;
  rx_state_e  dbg_state;

  uart_rx_stdin #(
    .BAUD       (BAUD),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .rx          (rx),
    .stdin_data  (stdin_data),
    .stdin_valid (stdin_valid),
    .stdin_ready (stdin_ready),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int got_rd = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  // Consumer-side monitor: every handshake seen here pops on the next rising edge.
  always @(negedge clk) begin
    if (stdin_valid && stdin_ready) got_q.push_back(stdin_data);
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_fe;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_next(input string name, input logic [7:0] exp);
    if (got_rd >= got_q.size()) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: byte missing, expected %0h", name, exp);
    end else begin
      chk(name, got_q[got_rd], exp);
      got_rd++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BAUD) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
    rx = 1'b1;
  endtask

  task automatic drain(input int n);
    stdin_ready = 1'b1;
    repeat (n) tick();
    stdin_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int fe0;
    int ov0;
    int exp_fe;
    logic [7:0] d;
    logic bad;
    logic done;

    tbl[0] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1};
    tbl[1] = '{8'h7E, 1'b1, 1'b1, 8'h7E, 0};
    tbl[2] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 0};
    tbl[3] = '{8'h80, 1'b0, 1'b0, 8'h00, 1};
    tbl[4] = '{8'h01, 1'b1, 1'b1, 8'h01, 0};

    repeat (3) tick();
    @(negedge clk);
    chk("reset valid", stdin_valid, 0);
    chk("reset data", stdin_data, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset overrun", overrun, 0);
    chk("reset state", dbg_state, ST_IDLE);
    tick();
    rstn = 1'b1;
    idle(10);

    // Single frame: valid rises exactly one clock after the stop sample.
    fork
      send_frame(8'h41, 1'b1);
      begin
        repeat (154) @(posedge clk);
        @(negedge clk);
        chk("t1 valid before stop sample", stdin_valid, 0);
        @(negedge clk);
        chk("t1 valid after stop sample", stdin_valid, 1);
        chk("t1 data", stdin_data, 8'h41);
      end
    join
    idle(4);
    stdin_ready = 1'b1;
    tick();
    stdin_ready = 1'b0;
    @(negedge clk);
    chk("t1 valid after pop", stdin_valid, 0);
    chk_next("t1 byte", 8'h41);
    tick();

    // Table of single frames, good and bad stop bits.
    for (int v = 0; v < 5; v++) begin
      fe0 = fe_cnt;
      send_frame(tbl[v].data, tbl[v].stop);
      idle(BAUD);
      @(negedge clk);
      chk($sformatf("tbl%0d valid", v), stdin_valid, tbl[v].exp_valid);
      if (tbl[v].exp_valid) chk($sformatf("tbl%0d data", v), stdin_data, tbl[v].exp_data);
      chk($sformatf("tbl%0d frame_err pulses", v), fe_cnt - fe0, tbl[v].exp_fe);
      tick();
      drain(1);
      if (tbl[v].exp_valid) chk_next($sformatf("tbl%0d popped", v), tbl[v].exp_data);
      @(negedge clk);
      chk($sformatf("tbl%0d valid after pop", v), stdin_valid, 0);
      tick();
    end

    // Back-to-back frames, consumer always ready.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    stdin_ready = 1'b1;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    send_frame(8'hA5, 1'b1);
    idle(20);
    stdin_ready = 1'b0;
    chk_next("b2b byte0", 8'h00);
    chk_next("b2b byte1", 8'hFF);
    chk_next("b2b byte2", 8'h55);
    chk_next("b2b byte3", 8'hA5);
    chk("b2b extra bytes", got_q.size(), got_rd);
    chk("b2b frame_err", fe_cnt - fe0, 0);
    chk("b2b overrun", ov_cnt - ov0, 0);

    // Overrun: five frames into a four-slot FIFO.
    ov0 = ov_cnt;
    for (int j = 1; j <= 5; j++) send_frame(8'(j), 1'b1);
    idle(8);
    @(negedge clk);
    chk("ovr overrun pulses", ov_cnt - ov0, 1);
    chk("ovr valid", stdin_valid, 1);
    tick();
    drain(4);
    for (int j = 1; j <= 4; j++) chk_next($sformatf("ovr byte%0d", j), 8'(j));
    @(negedge clk);
    chk("ovr valid after drain", stdin_valid, 0);
    chk("ovr extra bytes", got_q.size(), got_rd);
    tick();

    // Push and pop on the same edge while full: no overrun, nothing lost.
    ov0 = ov_cnt;
    for (int j = 0; j < 4; j++) send_frame(8'h11 + 8'(j), 1'b1);
    fork
      send_frame(8'h15, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1 stdin_ready = 1'b1;
        @(posedge clk);
        #1 stdin_ready = 1'b0;
      end
    join
    idle(4);
    chk("full pushpop overrun", ov_cnt - ov0, 0);
    drain(4);
    for (int j = 0; j < 5; j++) chk_next($sformatf("full pushpop byte%0d", j), 8'h11 + 8'(j));
    @(negedge clk);
    chk("full pushpop valid after drain", stdin_valid, 0);
    tick();

    // Short low glitch on an idle line is rejected silently.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    @(negedge clk);
    chk("glitch enters start", dbg_state, ST_START);
    idle(12);
    @(negedge clk);
    chk("glitch back to idle", dbg_state, ST_IDLE);
    chk("glitch valid", stdin_valid, 0);
    chk("glitch frame_err", fe_cnt - fe0, 0);
    chk("glitch overrun", ov_cnt - ov0, 0);
    tick();

    // Reset during data bit 3 clears a buffered byte and abandons the frame.
    send_frame(8'h99, 1'b1);
    idle(4);
    @(negedge clk);
    chk("rst buffered valid", stdin_valid, 1);
    tick();
    d = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    rx = d[3];
    repeat (8) tick();
    rstn = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    chk("rst valid", stdin_valid, 0);
    chk("rst data", stdin_data, 0);
    chk("rst frame_err", frame_err, 0);
    chk("rst overrun", overrun, 0);
    chk("rst state", dbg_state, ST_IDLE);
    repeat (3) tick();
    rstn = 1'b1;
    idle(20);
    send_frame(8'h12, 1'b1);
    idle(4);
    @(negedge clk);
    chk("rst new valid", stdin_valid, 1);
    chk("rst new data", stdin_data, 8'h12);
    tick();
    drain(2);
    chk_next("rst new byte", 8'h12);
    chk("rst extra bytes", got_q.size(), got_rd);

    // Randomized stream: good bytes must arrive in order, bad frames only raise frame_err.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    exp_fe = 0;
    exp_q.delete();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          d = 8'($urandom_range(0, 255));
          bad = ($urandom_range(0, 99) < 15);
          send_frame(d, !bad);
          if (bad) begin
            exp_fe++;
            idle(BAUD + $urandom_range(0, 8));
          end else begin
            exp_q.push_back(d);
            idle($urandom_range(0, 10));
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          stdin_ready = 1'($urandom_range(0, 1));
          tick();
        end
        stdin_ready = 1'b0;
      end
    join
    drain(10);
    foreach (exp_q[k]) chk_next($sformatf("rand byte%0d", k), exp_q[k]);
    chk("rand extra bytes", got_q.size(), got_rd);
    chk("rand frame_err pulses", fe_cnt - fe0, exp_fe);
    chk("rand overrun", ov_cnt - ov0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
